// File: rtl/puf_soc_ro_cmp_if.sv
// puf_soc_ro_cmp_if
//   Request/response bundle for the ring-oscillator PUF comparator.
//   master: the requester (drives start, selects, window, ready).
//   slave : the comparator (drives busy, valid, result and counts).
//   Signals:
//     i_start, i_sel_a, i_sel_b, i_win   - measurement request
//     o_busy                             - comparator not idle
//     o_valid, i_ready                   - result handshake
//     o_resp, o_tie, o_err               - result flags
//     o_cnt_a, o_cnt_b                   - final edge counts
interface puf_soc_ro_cmp_if #(
    parameter int N_RO  = 8,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    localparam int SEL_W = $clog2(N_RO);

    logic             i_start;
    logic [SEL_W-1:0] i_sel_a;
    logic [SEL_W-1:0] i_sel_b;
    logic [WIN_W-1:0] i_win;
    logic             o_busy;
    logic             o_valid;
    logic             i_ready;
    logic             o_resp;
    logic             o_tie;
    logic             o_err;
    logic [CNT_W-1:0] o_cnt_a;
    logic [CNT_W-1:0] o_cnt_b;

    modport master (
        output i_start, i_sel_a, i_sel_b, i_win, i_ready,
        input  o_busy, o_valid, o_resp, o_tie, o_err, o_cnt_a, o_cnt_b
    );

    modport slave (
        input  i_start, i_sel_a, i_sel_b, i_win, i_ready,
        output o_busy, o_valid, o_resp, o_tie, o_err, o_cnt_a, o_cnt_b
    );
endinterface

// File: rtl/puf_soc_ro_cmp.sv
// puf_soc_ro_cmp
//   Ring-oscillator PUF comparator. On a start request two oscillators of
//   the bank are enabled, allowed to settle, and their rising edges are
//   counted over a window of i_win clock cycles. The response bit is 1 when
//   RO A produced more edges than RO B.
//   Ports:
//     i_clk   - system clock, all state on rising edge
//     i_rst   - synchronous active-high reset
//     bus     - request/response bundle (slave side)
//     i_ro    - raw oscillator outputs, asynchronous to i_clk
//     o_ro_en - per-oscillator enable
//   The interface instance must use the same N_RO/CNT_W/WIN_W values.
module puf_soc_ro_cmp #(
    parameter int N_RO   = 8,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    puf_soc_ro_cmp_if.slave bus,
    input  logic [N_RO-1:0] i_ro,
    output logic [N_RO-1:0] o_ro_en
);
    localparam int SEL_W = $clog2(N_RO);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [WIN_W-1:0] win_len;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             resp;
    logic             tie;
    logic             err;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [N_RO-1:0]  ro_en;
    logic             accept;
    logic             illegal;
    logic             timer_zero;
    logic             rise_a;
    logic             rise_b;

    assign illegal = (bus.i_sel_a == bus.i_sel_b) ||
                     (bus.i_win == '0) ||
                     (int'(bus.i_sel_a) >= N_RO) ||
                     (int'(bus.i_sel_b) >= N_RO);

    assign timer_zero = (timer == '0);

    // sync[0], sync[1] form the synchronizer; sync[2] is the previous value.
    assign rise_a = sync_a[1] & ~sync_a[2];
    assign rise_b = sync_b[1] & ~sync_b[2];

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    accept  = 1'b1;
                    state_n = illegal ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: if (timer_zero) state_n = ST_COUNT;
            ST_COUNT:  if (timer_zero) state_n = ST_DRAIN;
            ST_DRAIN:  if (timer_zero) state_n = ST_DONE;
            ST_DONE:   if (bus.i_ready) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_a   <= '0;
            sel_b   <= '0;
            win_len <= '0;
            timer   <= '0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            resp    <= 1'b0;
            tie     <= 1'b0;
            err     <= 1'b0;
            sync_a  <= '0;
            sync_b  <= '0;
            ro_en   <= '0;
        end else begin
            // The selected oscillator is muxed ahead of the first flop; the
            // selection is static for the whole time the ROs are enabled.
            sync_a <= {sync_a[1:0], i_ro[sel_a]};
            sync_b <= {sync_b[1:0], i_ro[sel_b]};
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sel_a   <= bus.i_sel_a;
                        sel_b   <= bus.i_sel_b;
                        win_len <= bus.i_win;
                        timer   <= TMR_W'(SETTLE - 1);
                        cnt_a   <= '0;
                        cnt_b   <= '0;
                        resp    <= 1'b0;
                        tie     <= 1'b0;
                        err     <= illegal;
                        if (!illegal) begin
                            ro_en <= (N_RO'(1) << bus.i_sel_a) |
                                     (N_RO'(1) << bus.i_sel_b);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        timer <= TMR_W'(win_len) - 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (rise_a && (cnt_a != '1)) begin
                        cnt_a <= cnt_a + 1'b1;
                    end
                    if (rise_b && (cnt_b != '1)) begin
                        cnt_b <= cnt_b + 1'b1;
                    end
                    if (timer_zero) begin
                        timer <= TMR_W'(1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (timer_zero) begin
                        ro_en <= '0;
                        resp  <= (cnt_a > cnt_b);
                        tie   <= (cnt_a == cnt_b);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ro_en     = ro_en;
    assign bus.o_busy  = (state != ST_IDLE);
    assign bus.o_valid = (state == ST_DONE);
    assign bus.o_resp  = resp;
    assign bus.o_tie   = tie;
    assign bus.o_err   = err;
    assign bus.o_cnt_a = cnt_a;
    assign bus.o_cnt_b = cnt_b;
endmodule
